serial_shifter_32bits: RTL
==========================

# serial_shifter_32bits

Multi-cycle shift unit that performs the right-shift and rotate operations (plus SLL) one bit position per clock, complementing the combinational left-shift helpers in the auxiliary datapath library. It accepts an operand, a shift amount and an operation code through a start/busy/done handshake. It returns the shifted word to the ALU result mux. Arithmetic right shift replicates bit 31, the same sign-fill rule as the 16→32 sign extender.

## Interface

Parameters:
- WIDTH, 32, operand/result width; must be a power of two.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low; asserting it clears all state immediately.
- start  input  1  request; sampled on the rising edge of clock.
- op  input  2  2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 ROTR.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- operand  input  WIDTH  value to shift.
- busy  output  1  high while shifting; start is ignored while busy.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  WIDTH  shifted value; held until the next accepted start.

## Operation

- The FSM has three states: IDLE, SHIFT and DONE.
- A start is accepted when the FSM is in IDLE or DONE, which allows back-to-back requests.
- On acceptance, the block latches operand into result, latches op, and loads count with shamt.
  - If shamt == 0, the next state is DONE.
  - Otherwise, the next state is SHIFT.
- In SHIFT, each cycle applies one 1-bit step to result and decrements count.
  - SLL: result <= {result[WIDTH-2:0], 1'b0}.
  - SRL: result <= {1'b0, result[WIDTH-1:1]}.
  - SRA: result <= {result[WIDTH-1], result[WIDTH-1:1]}.
  - ROTR: result <= {result[0], result[WIDTH-1:1]}.
  - When count == 1, the FSM applies the final step and goes to DONE.
- DONE lasts one cycle with done=1. The next state is IDLE, unless a new start is accepted.
- In SHIFT, start is ignored: it is neither queued nor able to corrupt the latched op or count.
- Changes to operand, op and shamt after acceptance have no effect.
- busy = (state == SHIFT). done = (state == DONE).
- All arithmetic is unsigned on count. Sign fill comes only from the latched result MSB.

## Timing

- Reset values: state IDLE, result 0, count 0, busy 0, done 0.
- Reset is asynchronous. An assertion mid-operation aborts the shift within the same cycle, with no done pulse.
- Define E as the edge that samples an accepted start.
  - busy is high from edge E+1 through edge E+shamt.
  - done is high for exactly one cycle, starting at edge E+shamt+1.
  - Latency is shamt+1 cycles. The minimum is 1 cycle, for shamt=0.
- result is registered and changes only on clock edges, and it is stable while done=1.
- During SHIFT, result shows partial values. Consumers use it only when done=1 or afterwards.
- A start that is high during the DONE cycle is accepted at that edge. In that case done drops and the FSM re-enters SHIFT, or DONE again if shamt=0.
- Throughput is one operation per shamt+1 cycles.

## Structure

- Package shifter_pkg holds:
  - typedef enum logic [1:0] shift_op_t {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROTR};
  - typedef enum logic [1:0] shifter_state_t {IDLE, SHIFT, DONE};
  - localparam defaults for WIDTH.
- Sub-module shift_step_1bit: purely combinational (op, value) → value shifted by one position. It is instantiated once in the datapath and can be reused by a future barrel shifter.
- The top level contains only the FSM, the count register and the result register.

## Test plan

- SRA: operand 0x80000000, shamt 4, start at edge E → busy high for 4 cycles, done at E+5, result 0xF8000000.
- SRL and ROTR:
  - SRL with the same inputs → 0x08000000.
  - ROTR of 0x00000001 by 1 → 0x80000000, done at E+2.
- SLL: operand 0x00000001, shamt 31 → done at E+32, result 0x80000000, busy high for exactly 31 cycles.
- shamt 0 with operand 0x12345678, any op → busy never high, done at E+1, result 0x12345678.
- Handshake:
  - Pulse start again mid-SHIFT with different operand/shamt → ignored, and the original result completes.
  - Start asserted during the DONE cycle → the new op is accepted, and there is no idle gap.
- Reset: drive reset low during SHIFT of a shamt-20 operation → busy, done and result go to 0 immediately. After release, no done pulse appears until a new start.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and defaults for the multi-cycle serial shifter.
//   shift_op_t      : operation encoding presented on the op port
//   shifter_state_t : control FSM states
package shifter_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_ROTR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shifter_state_t;

endpackage

// File: rtl/shift_step_1bit.sv
// Combinational single-position shift/rotate step.
// Ports:
//   op_i    : operation (SLL, SRL, SRA, ROTR)
//   value_i : word to shift
//   value_o : value_i moved by one bit position
module shift_step_1bit
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  shift_op_t        op_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    case (op_i)
      SHIFT_SLL:  value_o = {value_i[WIDTH-2:0], 1'b0};
      SHIFT_SRL:  value_o = {1'b0, value_i[WIDTH-1:1]};
      // Sign fill comes from the current MSB of the word being shifted.
      SHIFT_SRA:  value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
      SHIFT_ROTR: value_o = {value_i[0], value_i[WIDTH-1:1]};
      default:    value_o = value_i;
    endcase
  end

endmodule

// File: rtl/serial_shifter_32bits.sv
// Multi-cycle shifter: one bit position per clock, start/busy/done handshake.
// Ports:
//   clock   : system clock, rising edge
//   reset   : asynchronous active-low reset
//   start   : request, accepted in IDLE or DONE
//   op      : 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   shamt   : shift amount 0..WIDTH-1
//   operand : value to shift
//   busy    : high while shifting
//   done    : one-cycle completion pulse
//   result  : shifted value, held until the next accepted start
module serial_shifter_32bits
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEFAULT,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   operand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  shifter_state_t     state_q, state_d;
  shift_op_t          op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   step_value;

  // Single datapath step applied to the working result each SHIFT cycle.
  shift_step_1bit #(
    .WIDTH(WIDTH)
  ) u_step (
    .op_i   (op_q),
    .value_i(result_q),
    .value_o(step_value)
  );

  // State, count, latched op and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= SHIFT_SLL;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        // Accepting in DONE as well gives back-to-back operation.
        if (start) begin
          result_d = operand;
          op_d     = shift_op_t'(op);
          count_d  = shamt;
          state_d  = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_d = step_value;
        count_d  = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
